pla_cover_eval_pipe: RTL and testbench

- Programmable sum-of-products (PLA cover) evaluator, parametrised in input count, product-term depth and output count.
- Streams one input vector per cycle and returns the cover outputs through a 2-stage pipeline with valid/ready handshakes.
- Optional symmetry-check mode evaluates f(x) and f(x XOR alpha) side by side. It flags and counts mismatches, for on-line validation of autosymmetric decompositions.
- Sits between the vector source and the result sink in the benchmark evaluation datapath.

---
 rtl/pla_cover_eval_pipe_if.sv | 49 ++++
 rtl/pla_cover_eval_pipe.sv | 125 ++++++++++++
 tb/tb_pla_cover_eval_pipe.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pla_cover_eval_pipe_if.sv
// Stream, config and status bundle for pla_cover_eval_pipe.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready valid-ready pairs; slave = evaluator, master = vector source/result sink.
interface pla_cover_eval_pipe_if #(
  parameter int N_IN    = 24,
  parameter int N_TERMS = 64,
  parameter int N_OUT   = 1,
  parameter int CNT_W   = 16
) ();
  localparam int AW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  // term-slot configuration
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [N_IN-1:0]  cfg_care;
  logic [N_IN-1:0]  cfg_val;
  logic [N_OUT-1:0] cfg_out;
  logic             cfg_err;
  // symmetry check control
  logic [N_IN-1:0]  alpha;
  logic             check_en;
  logic             cnt_clr;
  // input stream
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_x;
  // output stream
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_y;
  logic             out_sym_err;
  // status
  logic [CNT_W-1:0] err_cnt;
  logic             busy;

  modport slave (
    input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_out,
    input  alpha, check_en, cnt_clr,
    input  in_valid, in_x, out_ready,
    output cfg_err, in_ready, out_valid, out_y, out_sym_err, err_cnt, busy
  );

  modport master (
    output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_out,
    output alpha, check_en, cnt_clr,
    output in_valid, in_x, out_ready,
    input  cfg_err, in_ready, out_valid, out_y, out_sym_err, err_cnt, busy
  );
endinterface

// File: rtl/pla_cover_eval_pipe.sv
// Programmable sum-of-products cover evaluator with optional f(x) vs f(x^alpha) symmetry check.
// Latency: 2 cycles from input transfer to out_valid (S1 operand register, S2 result register).
// Backpressure: advance = !out_valid | out_ready; whole pipe freezes when the sink stalls.
//
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the term-slot write port
// (cfg_*), symmetry controls (alpha, check_en, cnt_clr), input stream (in_valid/in_ready/in_x),
// output stream (out_valid/out_ready/out_y/out_sym_err) and status (err_cnt, busy).
module pla_cover_eval_pipe #(
  parameter int N_IN    = 24,
  parameter int N_TERMS = 64,
  parameter int N_OUT   = 1,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pla_cover_eval_pipe_if.slave  bus
);
  // cover memory
  logic [N_IN-1:0]  care_q [N_TERMS];
  logic [N_IN-1:0]  val_q  [N_TERMS];
  logic [N_OUT-1:0] out_q  [N_TERMS];

  // S1: operands
  logic             s1_vld;
  logic             s1_chk;
  logic [N_IN-1:0]  s1_x;
  logic [N_IN-1:0]  s1_xa;

  // S2: results (this is the output register)
  logic             s2_vld;
  logic [N_OUT-1:0] s2_y;
  logic             s2_sym;

  logic [CNT_W-1:0] cnt_q;
  logic             cfg_err_q;

  logic             advance;
  logic             in_xfer;
  logic             out_xfer;
  logic             busy;
  logic             cfg_ok;
  logic [N_OUT-1:0] f_x;
  logic [N_OUT-1:0] f_xa;

  assign advance  = !s2_vld || bus.out_ready;
  assign in_xfer  = bus.in_valid && advance;
  assign out_xfer = s2_vld && bus.out_ready;
  // s2_vld doubles as out_valid, so this covers every stage
  assign busy     = s1_vld || s2_vld;
  // Writes only land when nothing is in flight or arriving, so a vector never sees a mixed cover.
  assign cfg_ok   = bus.cfg_we && !busy && !bus.in_valid;

  // Evaluate both operands against every slot; care=0 matches all, out=0 contributes nothing.
  always_comb begin
    f_x  = '0;
    f_xa = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      if (((s1_x ^ val_q[t]) & care_q[t]) == '0)
        f_x = f_x | out_q[t];
      if (((s1_xa ^ val_q[t]) & care_q[t]) == '0)
        f_xa = f_xa | out_q[t];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N_TERMS; t++) begin
        care_q[t] <= '0;
        val_q[t]  <= '0;
        out_q[t]  <= '0;
      end
    end else if (cfg_ok) begin
      care_q[bus.cfg_addr] <= bus.cfg_care;
      val_q[bus.cfg_addr]  <= bus.cfg_val;
      out_q[bus.cfg_addr]  <= bus.cfg_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cfg_err_q <= 1'b0;
    else
      cfg_err_q <= bus.cfg_we && !cfg_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_chk <= 1'b0;
      s1_x   <= '0;
      s1_xa  <= '0;
      s2_vld <= 1'b0;
      s2_y   <= '0;
      s2_sym <= 1'b0;
    end else if (advance) begin
      s1_vld <= bus.in_valid;
      if (in_xfer) begin
        s1_x   <= bus.in_x;
        s1_xa  <= bus.in_x ^ bus.alpha;
        s1_chk <= bus.check_en;
      end
      s2_vld <= s1_vld;
      // bubbles keep the last out_y but never carry a stale sym flag
      s2_sym <= s1_vld && s1_chk && (f_x != f_xa);
      if (s1_vld)
        s2_y <= f_x;
    end
  end

  // cnt_clr has priority over a same-cycle increment; saturates at all-ones
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr)
      cnt_q <= '0;
    else if (out_xfer && s2_sym && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.in_ready    = advance;
  assign bus.out_valid   = s2_vld;
  assign bus.out_y       = s2_y;
  assign bus.out_sym_err = s2_sym;
  assign bus.err_cnt     = cnt_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.busy        = busy;
endmodule

// File: tb/tb_pla_cover_eval_pipe.sv
module tb_pla_cover_eval_pipe;
  localparam int N_IN    = 24;
  localparam int N_TERMS = 64;
  localparam int N_OUT   = 1;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pla_cover_eval_pipe_if #(.N_IN(N_IN), .N_TERMS(N_TERMS), .N_OUT(N_OUT), .CNT_W(CNT_W)) bus ();

  pla_cover_eval_pipe #(.N_IN(N_IN), .N_TERMS(N_TERMS), .N_OUT(N_OUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference cover and in-flight results
  logic [N_IN-1:0]  m_care [N_TERMS];
  logic [N_IN-1:0]  m_val  [N_TERMS];
  logic [N_OUT-1:0] m_out  [N_TERMS];

  typedef struct {
    logic [N_OUT-1:0] y;
    logic             sym;
    int               age;    // advancing edges since acceptance; visible at the output at 2
    logic             has_tbl;
    logic [N_OUT-1:0] tbl_y;
  } ent_t;
  ent_t q[$];
  int   cnt_m = 0;
  logic cfg_err_m = 1'b0;
  logic last_ixf = 1'b0;
  logic tbl_flag = 1'b0;
  logic [N_OUT-1:0] tbl_y_drv = '0;

  typedef struct {
    logic [N_IN-1:0]  x;
    logic [N_OUT-1:0] y;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N_OUT-1:0] f_ref(input logic [N_IN-1:0] v);
    logic [N_OUT-1:0] r;
    r = '0;
    for (int t = 0; t < N_TERMS; t++)
      if (((v ^ m_val[t]) & m_care[t]) == '0) r = r | m_out[t];
    return r;
  endfunction

  // Inputs are set just after a negedge; this compares, updates the model, and steps one cycle.
  task automatic tick();
    ent_t e, tmp;
    logic ov, adv, oxf, ixf, acc;
    #1;
    ov  = (q.size() > 0) && (q[0].age >= 2);
    adv = !ov || bus.out_ready;
    chk("out_valid", bus.out_valid, ov);
    chk("in_ready", bus.in_ready, adv);
    chk("busy", bus.busy, q.size() != 0);
    chk("err_cnt", bus.err_cnt, cnt_m);
    chk("cfg_err", bus.cfg_err, cfg_err_m);
    if (ov) begin
      chk("out_y", bus.out_y, q[0].y);
      chk("out_sym_err", bus.out_sym_err, q[0].sym);
      if (q[0].has_tbl) chk("tbl_y", bus.out_y, q[0].tbl_y);
    end
    if (rst) begin
      q.delete();
      cnt_m = 0;
      cfg_err_m = 1'b0;
      last_ixf = 1'b0;
      for (int t = 0; t < N_TERMS; t++) begin
        m_care[t] = '0; m_val[t] = '0; m_out[t] = '0;
      end
    end else begin
      oxf = ov && bus.out_ready;
      ixf = bus.in_valid && adv;
      acc = bus.cfg_we && (q.size() == 0) && !bus.in_valid;
      cfg_err_m = bus.cfg_we && !acc;
      last_ixf = ixf;
      if (oxf) begin
        if (q[0].sym && cnt_m < CNT_MAX) cnt_m++;
        void'(q.pop_front());
      end
      if (bus.cnt_clr) cnt_m = 0;
      if (ixf) begin
        e.y       = f_ref(bus.in_x);
        e.sym     = bus.check_en && (f_ref(bus.in_x) != f_ref(bus.in_x ^ bus.alpha));
        e.age     = 0;
        e.has_tbl = tbl_flag;
        e.tbl_y   = tbl_y_drv;
        q.push_back(e);
      end
      if (adv)
        for (int i = 0; i < q.size(); i++) begin
          tmp = q[i]; tmp.age++; q[i] = tmp;
        end
      if (acc) begin
        m_care[bus.cfg_addr] = bus.cfg_care;
        m_val[bus.cfg_addr]  = bus.cfg_val;
        m_out[bus.cfg_addr]  = bus.cfg_out;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [N_IN-1:0] x, input logic ce, input logic [N_IN-1:0] a);
    bit done;
    done = 0;
    bus.in_valid = 1'b1; bus.in_x = x; bus.check_en = ce; bus.alpha = a;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (last_ixf) done = 1;
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && q.size() != 0; k++) tick();
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic cfg_write(input int addr, input logic [N_IN-1:0] care,
                           input logic [N_IN-1:0] val, input logic [N_OUT-1:0] o);
    bus.cfg_we = 1'b1; bus.cfg_addr = addr[5:0];
    bus.cfg_care = care; bus.cfg_val = val; bus.cfg_out = o;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic [N_IN-1:0] r;
    tbl[0] = '{24'h1234A5, 1'b1};
    tbl[1] = '{24'h1234A4, 1'b0};
    tbl[2] = '{24'h0000A5, 1'b1};
    tbl[3] = '{24'hFFFFA5, 1'b1};
    tbl[4] = '{24'hFFFF5A, 1'b0};
    tbl[5] = '{24'h0000A7, 1'b0};
    tbl[6] = '{24'hABCDA5, 1'b1};
    tbl[7] = '{24'h0000FF, 1'b0};

    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_care = '0; bus.cfg_val = '0; bus.cfg_out = '0;
    bus.alpha = '0; bus.check_en = 0; bus.cnt_clr = 0;
    bus.in_valid = 0; bus.in_x = '0; bus.out_ready = 1;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    tick();                       // reset state vs cleared model
    rst = 1'b0;

    // empty cover: everything evaluates 0
    tbl_flag = 1; tbl_y_drv = 1'b0;
    send(24'h000000, 0, '0);
    send(24'hFFFFFF, 0, '0);
    tbl_flag = 0;
    drain();

    // slot 3: low byte must equal A5; table streamed back-to-back
    cfg_write(3, 24'h0000FF, 24'h0000A5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tbl_flag = 1; tbl_y_drv = tbl[i].y;
      send(tbl[i].x, 0, '0);
    end
    tbl_flag = 0;
    drain();

    // sink stall while streaming 4 vectors
    bus.out_ready = 0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (idx < 4);
      bus.in_x = tbl[idx % 8].x; tbl_flag = 1; tbl_y_drv = tbl[idx % 8].y;
      tick();
      if (last_ixf) idx++;
    end
    chk("stall_accepts", idx, 2);
    bus.out_ready = 1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_x = tbl[idx].x; tbl_y_drv = tbl[idx].y;
      tick();
      if (last_ixf) idx++;
    end
    bus.in_valid = 0; tbl_flag = 0;
    chk("stall_all_sent", idx, 4);
    drain();

    // symmetry check
    send(24'h0000A5, 1, 24'h000001);
    drain();
    chk("sym_cnt1", bus.err_cnt, 1);
    send(24'h0000A5, 1, 24'h100000);
    drain();
    chk("sym_cnt_hold", bus.err_cnt, 1);

    // write while busy is dropped
    send(24'h000000, 0, '0);
    cfg_write(5, 24'hFFFFFF, 24'h00000F, 1'b1);
    chk("cfg_err_pulse", bus.cfg_err, 1);
    tick();
    chk("cfg_err_one_cycle", bus.cfg_err, 0);
    drain();
    tbl_flag = 1; tbl_y_drv = 1'b0;
    send(24'h00000F, 0, '0);
    tbl_flag = 0;
    drain();
    cfg_write(5, 24'hFFFFFF, 24'h00000F, 1'b1);
    chk("cfg_ok_no_err", bus.cfg_err, 0);
    tbl_flag = 1; tbl_y_drv = 1'b1;
    send(24'h00000F, 0, '0);
    tbl_flag = 0;
    drain();

    // saturation, then clear racing an increment
    for (int i = 0; i < 20; i++) send(24'h0000A5, 1, 24'h000001);
    drain();
    chk("sat_hold", bus.err_cnt, CNT_MAX);
    send(24'h0000A5, 1, 24'h000001);
    tick();
    bus.cnt_clr = 1;
    tick();                       // output transfer of a mismatch in this cycle
    bus.cnt_clr = 0;
    chk("cnt_clr_wins", bus.err_cnt, 0);
    drain();

    // reset with two vectors in flight
    send(24'h0000A5, 1, 24'h000001);
    send(24'h0000A5, 1, 24'h000001);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_flush", bus.out_valid, 0);
    tbl_flag = 1; tbl_y_drv = 1'b0;
    send(24'h0000A5, 0, '0);
    tbl_flag = 0;
    drain();

    // randomized traffic with sparse random cover
    for (int i = 0; i < 8; i++)
      cfg_write(i, $urandom & $urandom & $urandom, $urandom, N_OUT'($urandom));
    for (int i = 0; i < 2000; i++) begin
      r = $urandom;
      bus.in_valid  = ((i % 40) < 28) && ($urandom_range(0, 3) != 0);
      bus.in_x      = r;
      bus.check_en  = $urandom_range(0, 1);
      bus.alpha     = ($urandom_range(0, 1) != 0) ? (24'h1 << $urandom_range(0, 23)) : N_IN'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.cnt_clr   = ($urandom_range(0, 63) == 0);
      bus.cfg_we    = ($urandom_range(0, 5) == 0);
      bus.cfg_addr  = 6'($urandom_range(0, 7));
      bus.cfg_care  = $urandom & $urandom & $urandom;
      bus.cfg_val   = $urandom;
      bus.cfg_out   = N_OUT'($urandom);
      tick();
    end
    bus.in_valid = 0; bus.cfg_we = 0; bus.cnt_clr = 0; bus.out_ready = 1;
    drain();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
